lcd1602_bus_decoder: RTL and testbench
======================================

Name: lcd1602_bus_decoder

Overview:
Passive receiver for the HD44780/LCD1602 8-bit write bus driven by the team's LCD writer blocks (lcd_rs, lcd_rw, lcd_en, lcd_data).
- Synchronises the bus into the clk domain and latches each transfer on the falling edge of lcd_en.
- Decodes instructions and character writes into a 32-byte on-chip shadow of the two visible 16-character lines.
- Sits beside the LCD pins for on-chip capture, for mirroring to UART/VGA, and as a bench checker for the LCD writers.

Parameters:
SYNC_STAGES, 2, synchroniser flops on every bus input (legal range 2-3)
MIN_EN_HIGH, 4, minimum synchronised lcd_en high time in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset; asynchronous, active-high (despite the name)
lcd_rs  in  1  register select; 0 = instruction, 1 = data
lcd_rw  in  1  read/write; 1 = read cycle, which is ignored
lcd_en  in  1  enable strobe; transfer is latched on its falling edge
lcd_data  in  8  bus data
rd_addr  in  5  shadow read index; 0-15 = line 1, 16-31 = line 2
rd_data  out  8  shadow byte at rd_addr, registered
ac  out  7  DDRAM address counter
busy  out  1  high while a clear is in progress
disp_on  out  1  display control D bit
cursor_on  out  1  display control C bit
blink_on  out  1  display control B bit
entry_inc  out  1  entry mode I/D bit
func_2line  out  1  function set N bit
wr_strobe  out  1  one-cycle pulse per accepted data write
cmd_strobe  out  1  one-cycle pulse per accepted instruction
bad_addr  out  1  one-cycle pulse when a set-DDRAM address is invalid
drop_flag  out  1  sticky; a transfer arrived while busy

Behaviour:
- Reset (asynchronous)
  - All outputs 0, except entry_inc = 1.
  - Shadow contents are not reset; they are defined by the first clear.
  - Reset during CLEAR aborts the clear immediately.
- Input capture
  - Every bus input passes through SYNC_STAGES flops.
  - A falling edge is defined as previous synced en = 1 and current synced en = 0.
  - rs/rw/data are taken from the synced stage aligned with the previous en sample.
- Latency
  - Strobes and register updates occur 1 clk after edge detection.
  - A shadow write is visible on rd_data 1 clk after wr_strobe, when rd_addr matches.
- Read cycles: a transfer with rw = 1 is discarded. No strobe, no state change.
- FSM state IDLE
  - Handles a transfer in one cycle, then stays in IDLE.
  - Exception: the clear instruction moves to CLEAR.
- FSM state CLEAR
  - Lasts 32 cycles, writing 0x20 to indices 0..31 in order, with busy = 1.
  - On exit: ac = 0, entry_inc = 1, return to IDLE.
  - A falling edge seen while in CLEAR is dropped and sets drop_flag. drop_flag is cleared only by reset.
- Instruction decode, by highest set bit:
  - 0x01 clear: go to CLEAR.
  - 0x02/0x03 return home: ac = 0.
  - 0x04-0x07 entry mode: entry_inc = bit1. The shift bit is ignored.
  - 0x08-0x0F display control: disp_on = bit2, cursor_on = bit1, blink_on = bit0.
  - 0x10-0x1F cursor/display shift: no effect.
  - 0x20-0x3F function set: func_2line = bit3.
  - 0x40-0x7F CGRAM address: ignored.
  - 0x80-0xFF set DDRAM address, with a = data[6:0]:
    - a in 0x00-0x27 or 0x40-0x67: ac = a.
    - Otherwise: ac = 0 and bad_addr pulses. Example: command 0xFF gives a = 0x7F, so ac = 0.
  - cmd_strobe pulses for every accepted instruction, including the ignored ones.
- Data write (rs = 1)
  - Shadow write rules:
    - ac 0x00-0x0F: write index ac.
    - ac 0x40-0x4F: write index ac - 0x30 (16-31).
    - Other ac values: no shadow write, but wr_strobe still pulses.
  - Then ac moves by one in the entry_inc direction:
    - Increment wraps 0x27 -> 0x40 and 0x67 -> 0x00.
    - Decrement wraps 0x00 -> 0x67 and 0x40 -> 0x27.
- Simultaneous events: when a shadow write and a read hit the same index in the same cycle, rd_data returns the old value.

Optional Feature:
LCD_EN_FILTER_EN
- Defined:
  - A falling edge is accepted only if synced en was high for at least MIN_EN_HIGH consecutive clk cycles.
  - A shorter pulse is discarded with no strobe and no drop_flag.
- Undefined:
  - Every synced falling edge is accepted.
  - MIN_EN_HIGH is unused.

Test Plan:
- Reset, then sequence 0x38, 0x0C, 0xFF, 0x01, each an en pulse of 10 cycles -> func_2line = 1, disp_on = 1, cursor_on = 0, bad_addr pulses once, busy high for 32 cycles, indices 0-31 read 0x20, ac = 0.
- After the clear, command 0x80 then data "C", "n", "t", ":" -> indices 0-3 = 0x43, 0x6E, 0x74, 0x3A, ac = 0x04, four wr_strobe pulses.
- Command 0xA7 (ac = 0x27), data 0x41 -> no shadow write, ac = 0x40. Next data 0x42 -> index 16 = 0x42, ac = 0x41.
- Command 0x04 (decrement), command 0xC0, data 0x5A -> index 16 = 0x5A, ac = 0x27.
- Issue 0x01, then an en pulse of data 0x55 during busy -> drop_flag = 1, all 32 indices 0x20 after the clear. Reset asserted mid-CLEAR -> busy = 0 on the next clk.
- With LCD_EN_FILTER_EN and MIN_EN_HIGH = 4: a 2-cycle en pulse of data 0x31 -> no wr_strobe, ac unchanged. A 6-cycle pulse -> accepted.

Source files
------------

// File: rtl/lcd1602_bus_decoder.sv
// Passive HD44780/LCD1602 write-bus decoder with a 32-byte shadow of both visible lines.
// Optional macro LCD_EN_FILTER_EN rejects lcd_en pulses shorter than MIN_EN_HIGH clk cycles.
module lcd1602_bus_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       func_2line,
  output logic       wr_strobe,
  output logic       cmd_strobe,
  output logic       bad_addr,
  output logic       drop_flag,
  output logic       dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam int CNT_W = $clog2(MIN_EN_HIGH + 1);
  localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(MIN_EN_HIGH);

  // Stage SYNC_STAGES-1 is the synced sample; stage SYNC_STAGES is the previous one.
  logic [SYNC_STAGES:0] r_en_sh;
  logic [9:0]           r_bus_sh [0:SYNC_STAGES];
  logic [CNT_W-1:0]     r_hi_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_en_sh  <= '0;
      r_hi_cnt <= '0;
      for (int i = 0; i <= SYNC_STAGES; i++) r_bus_sh[i] <= '0;
    end else begin
      r_en_sh     <= {r_en_sh[SYNC_STAGES-1:0], lcd_en};
      r_bus_sh[0] <= {lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i <= SYNC_STAGES; i++) r_bus_sh[i] <= r_bus_sh[i-1];
      if (!r_en_sh[SYNC_STAGES-1])  r_hi_cnt <= '0;
      else if (r_hi_cnt != LP_MIN)  r_hi_cnt <= r_hi_cnt + 1'b1;
    end
  end

  logic       w_fall, w_edge, w_rs, w_rw;
  logic [7:0] w_data;
  logic [6:0] w_a, w_ac_inc, w_ac_dec;
  logic       w_a_valid;

  assign w_fall = r_en_sh[SYNC_STAGES] & ~r_en_sh[SYNC_STAGES-1];
`ifdef LCD_EN_FILTER_EN
  assign w_edge = w_fall & (r_hi_cnt == LP_MIN);
`else
  assign w_edge = w_fall;
`endif
  assign {w_rs, w_rw, w_data} = r_bus_sh[SYNC_STAGES];
  assign w_a       = w_data[6:0];
  assign w_a_valid = (w_a <= 7'h27) || ((w_a >= 7'h40) && (w_a <= 7'h67));

  state_t     r_state, w_state_nxt;
  logic [4:0] r_clr_idx, w_clr_idx_nxt;
  logic [6:0] r_ac, w_ac_nxt;
  logic       r_disp, r_cur, r_blink, r_inc, r_2line, r_wr, r_cmd, r_bad, r_drop;
  logic       w_disp_nxt, w_cur_nxt, w_blink_nxt, w_inc_nxt, w_2line_nxt;
  logic       w_wr_nxt, w_cmd_nxt, w_bad_nxt, w_drop_nxt;
  logic       w_we;
  logic [4:0] w_widx;
  logic [7:0] w_wdata;

  // DDRAM addresses form two 40-column lines at 0x00 and 0x40 that wrap into each other.
  assign w_ac_inc = (r_ac == 7'h27) ? 7'h40 : (r_ac == 7'h67) ? 7'h00 : r_ac + 7'd1;
  assign w_ac_dec = (r_ac == 7'h00) ? 7'h67 : (r_ac == 7'h40) ? 7'h27 : r_ac - 7'd1;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
      r_ac      <= '0;
      r_disp    <= 1'b0;
      r_cur     <= 1'b0;
      r_blink   <= 1'b0;
      r_inc     <= 1'b1;
      r_2line   <= 1'b0;
      r_wr      <= 1'b0;
      r_cmd     <= 1'b0;
      r_bad     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_ac      <= w_ac_nxt;
      r_disp    <= w_disp_nxt;
      r_cur     <= w_cur_nxt;
      r_blink   <= w_blink_nxt;
      r_inc     <= w_inc_nxt;
      r_2line   <= w_2line_nxt;
      r_wr      <= w_wr_nxt;
      r_cmd     <= w_cmd_nxt;
      r_bad     <= w_bad_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_ac_nxt      = r_ac;
    w_disp_nxt    = r_disp;
    w_cur_nxt     = r_cur;
    w_blink_nxt   = r_blink;
    w_inc_nxt     = r_inc;
    w_2line_nxt   = r_2line;
    w_wr_nxt      = 1'b0;
    w_cmd_nxt     = 1'b0;
    w_bad_nxt     = 1'b0;
    w_drop_nxt    = r_drop;
    w_we          = 1'b0;
    w_widx        = '0;
    w_wdata       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge && !w_rw) begin
          if (w_rs) begin
            w_wr_nxt = 1'b1;
            w_wdata  = w_data;
            // Only the first 16 columns of each line are visible and shadowed.
            if (r_ac[6:4] == 3'b000) begin
              w_we   = 1'b1;
              w_widx = {1'b0, r_ac[3:0]};
            end else if (r_ac[6:4] == 3'b100) begin
              w_we   = 1'b1;
              w_widx = {1'b1, r_ac[3:0]};
            end
            w_ac_nxt = r_inc ? w_ac_inc : w_ac_dec;
          end else begin
            w_cmd_nxt = 1'b1;
            casez (w_data)
              8'b1???_????: begin
                w_ac_nxt  = w_a_valid ? w_a : 7'h00;
                w_bad_nxt = ~w_a_valid;
              end
              8'b01??_????: ;
              8'b001?_????: w_2line_nxt = w_data[3];
              8'b0001_????: ;
              8'b0000_1???: {w_disp_nxt, w_cur_nxt, w_blink_nxt} = w_data[2:0];
              8'b0000_01??: w_inc_nxt = w_data[1];
              8'b0000_001?: w_ac_nxt = 7'h00;
              8'b0000_0001: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = 5'd0;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        w_we          = 1'b1;
        w_widx        = r_clr_idx;
        w_wdata       = 8'h20;
        w_clr_idx_nxt = r_clr_idx + 5'd1;
        if (w_edge) w_drop_nxt = 1'b1;
        if (r_clr_idx == 5'd31) begin
          w_state_nxt = ST_IDLE;
          w_ac_nxt    = 7'h00;
          w_inc_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic [7:0] r_mem [0:31];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
  end

  // Reading the array before the same-edge write lands returns the old byte on a collision.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_rd_data <= '0;
    else       r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data    = r_rd_data;
  assign ac         = r_ac;
  assign busy       = (r_state == ST_CLEAR);
  assign disp_on    = r_disp;
  assign cursor_on  = r_cur;
  assign blink_on   = r_blink;
  assign entry_inc  = r_inc;
  assign func_2line = r_2line;
  assign wr_strobe  = r_wr;
  assign cmd_strobe = r_cmd;
  assign bad_addr   = r_bad;
  assign drop_flag  = r_drop;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lcd1602_bus_decoder.sv
// Scoreboard bench for lcd1602_bus_decoder: a transaction-level LCD model predicts each strobe.
// Handshake: every accepted transfer produces exactly one one-cycle wr_strobe or cmd_strobe.
module tb_lcd1602_bus_decoder;
  localparam int SYNC_STAGES = 2;
  localparam int MIN_EN_HIGH = 4;
  localparam int EW = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic       busy, disp_on, cursor_on, blink_on, entry_inc, func_2line;
  logic       wr_strobe, cmd_strobe, bad_addr, drop_flag, dbg_state;

  lcd1602_bus_decoder #(.SYNC_STAGES(SYNC_STAGES), .MIN_EN_HIGH(MIN_EN_HIGH)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac), .busy(busy),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
    .func_2line(func_2line), .wr_strobe(wr_strobe), .cmd_strobe(cmd_strobe),
    .bad_addr(bad_addr), .drop_flag(drop_flag), .dbg_state(dbg_state)
  );

  always #10 clk = ~clk;

  // Reference model: cursor is a linear position 0..79 over two 40-column lines.
  int          m_pos;
  bit          m_disp, m_cur, m_blink, m_inc, m_2line;
  logic [7:0]  m_shadow [32];
  bit          m_shadow_valid;
  logic [EW-1:0] exp_q[$];

  int n_checks = 0, n_errors = 0;
  int bad_seen = 0, wr_seen = 0, busy_run = 0, last_busy_run = 0;

  function automatic logic [6:0] pos_to_ac(int p);
    return 7'((p / 40) * 64 + (p % 40));
  endfunction

  function automatic logic [EW-1:0] pack(bit wr, bit cmd, bit bad, logic [6:0] a,
                                         bit d, bit c, bit b, bit i, bit n);
    return {wr, cmd, bad, a, d, c, b, i, n};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_2line = 0;
    m_shadow_valid = 0;
  endtask

  // Returns 1 when the transfer is a clear that the caller must wait out.
  function automatic bit model_apply(bit rs, logic [7:0] d);
    int msb = -1;
    bit bad = 0, is_clear = 0;
    int line, col;
    if (rs) begin
      line = m_pos / 40; col = m_pos % 40;
      if (col < 16) m_shadow[line * 16 + col] = d;
      m_pos = m_inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
    end else begin
      for (int b = 7; b >= 0; b--) if (d[b] && msb < 0) msb = b;
      case (msb)
        7: begin
          line = (d[6:0] >= 7'h40) ? 1 : 0;
          col  = int'(d[6:0]) - line * 64;
          if (col < 40) m_pos = line * 40 + col;
          else begin m_pos = 0; bad = 1; end
        end
        5: m_2line = d[3];
        3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        2: m_inc = d[1];
        1: m_pos = 0;
        0: is_clear = 1;
        default: ;
      endcase
    end
    exp_q.push_back(pack(rs, !rs, bad, pos_to_ac(m_pos), m_disp, m_cur, m_blink, m_inc, m_2line));
    return is_clear;
  endfunction

  task automatic xfer(bit rs, bit rw, logic [7:0] d, int hi);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_en = 1'b0;
    repeat (2) @(negedge clk);
    lcd_rs = 1'($urandom); lcd_rw = 1'($urandom); lcd_data = 8'($urandom);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_clear();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_checks++; n_errors++;
      $display("FAIL clear_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
    m_shadow_valid = 1; m_pos = 0; m_inc = 1;
  endtask

  task automatic issue(bit rs, bit rw, logic [7:0] d, int hi);
    bit acc = 1, clr = 0;
`ifdef LCD_EN_FILTER_EN
    if (hi < MIN_EN_HIGH) acc = 0;
`endif
    if (acc && !rw) clr = model_apply(rs, d);
    xfer(rs, rw, d, hi);
    if (clr) wait_clear();
  endtask

  task automatic check_regs(string tag);
    check({tag, "_ac"}, 32'(ac), 32'(pos_to_ac(m_pos)));
    check({tag, "_ctrl"}, {disp_on, cursor_on, blink_on, entry_inc, func_2line},
          {m_disp, m_cur, m_blink, m_inc, m_2line});
  endtask

  task automatic check_shadow(string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      check($sformatf("%s_idx%0d", tag, i), 32'(rd_data), 32'(m_shadow[i]));
    end
  endtask

  task automatic monitor();
    logic [EW-1:0] got, exp;
    forever begin
      @(negedge clk);
      if (busy) busy_run++;
      else begin
        if (busy_run != 0) last_busy_run = busy_run;
        busy_run = 0;
      end
      if (bad_addr) bad_seen++;
      if (wr_strobe) wr_seen++;
      if (wr_strobe || cmd_strobe) begin
        got = pack(wr_strobe, cmd_strobe, bad_addr, ac, disp_on, cursor_on, blink_on,
                   entry_inc, func_2line);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_strobe: got %h, required no strobe", got);
        end else begin
          exp = exp_q.pop_front();
          check("strobe_event", 32'(got), 32'(exp));
        end
      end
    end
  endtask

  initial begin
    int bad0, wr0;
    string txt;
    rst_n = 1'b1; lcd_rs = 0; lcd_rw = 0; lcd_en = 0; lcd_data = 0; rd_addr = 0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("reset_outputs",
          {ac, busy, disp_on, cursor_on, blink_on, entry_inc, func_2line,
           wr_strobe, cmd_strobe, bad_addr, drop_flag, rd_data},
          {7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});

    // Power-up style init sequence ending with a clear.
    bad0 = bad_seen;
    issue(0, 0, 8'h38, 10);
    issue(0, 0, 8'h0C, 10);
    issue(0, 0, 8'hFF, 10);
    issue(0, 0, 8'h01, 10);
    check("init_bad_addr_pulses", 32'(bad_seen - bad0), 32'd1);
    check("init_busy_cycles", 32'(last_busy_run), 32'd32);
    check("init_flags", {func_2line, disp_on, cursor_on, ac}, {1'b1, 1'b1, 1'b0, 7'h00});
    check_regs("init");
    check_shadow("init");

    wr0 = wr_seen;
    txt = "Cnt:";
    issue(0, 0, 8'h80, 10);
    for (int i = 0; i < 4; i++) issue(1, 0, txt[i], 6);
    check("cnt_wr_strobes", 32'(wr_seen - wr0), 32'd4);
    check("cnt_ac", 32'(ac), 32'h04);
    check_shadow("cnt");

    issue(0, 0, 8'hA7, 6);
    issue(1, 0, 8'h41, 6);
    check("wrap_line1_ac", 32'(ac), 32'h40);
    issue(1, 0, 8'h42, 6);
    check("line2_ac", 32'(ac), 32'h41);
    issue(0, 0, 8'h04, 6);
    issue(0, 0, 8'hC0, 6);
    issue(1, 0, 8'h5A, 6);
    check("dec_wrap_ac", 32'(ac), 32'h27);
    check_shadow("wrap");

    // Transfer during clear is dropped.
    issue(0, 0, 8'h01, 10);
    check("drop_flag_before", 32'(drop_flag), 32'd0);
    model_reset_keep_regs: begin end
    // Re-issue a clear manually so a data pulse can land while busy.
    void'(model_apply(0, 8'h01));
    xfer(0, 0, 8'h01, 10);
    check("busy_during_clear", 32'(busy), 32'd1);
    xfer(1, 0, 8'h55, 4);
    wait_clear();
    check("drop_flag_set", 32'(drop_flag), 32'd1);
    check_regs("after_drop");
    check_shadow("after_drop");

    // Randomized traffic, including invalid addresses and ignored read cycles.
    for (int t = 0; t < 160; t++) begin
      int k = $urandom_range(0, 99);
      int hi = $urandom_range(1, 10);
      if (k < 50)      issue(1, 0, 8'($urandom), hi);
      else if (k < 68) issue(0, 0, 8'h80 | 8'($urandom_range(0, 127)), hi);
      else if (k < 88) issue(0, 0, 8'($urandom_range(2, 127)), hi);
      else if (k < 97) issue(1'($urandom), 1, 8'($urandom), hi);
      else             issue(0, 0, 8'h01, 10);
      if (t % 40 == 39) check_regs($sformatf("rand%0d", t));
    end
    check_shadow("rand");

`ifdef LCD_EN_FILTER_EN
    wr0 = wr_seen;
    issue(0, 0, 8'h80, 6);
    issue(1, 0, 8'h31, 2);
    check("filter_short_wr", 32'(wr_seen - wr0), 32'd0);
    check("filter_short_ac", 32'(ac), 32'h00);
    issue(1, 0, 8'h31, 6);
    check("filter_long_wr", 32'(wr_seen - wr0), 32'd1);
    check("filter_long_ac", 32'(ac), 32'h01);
`endif

    // Reset in the middle of a clear aborts it at once.
    void'(model_apply(0, 8'h01));
    xfer(0, 0, 8'h01, 10);
    check("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b1;
    #1 check("busy_abort", {busy, dbg_state}, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_reset", {drop_flag, ac, entry_inc, disp_on, func_2line},
          {1'b0, 7'h00, 1'b1, 1'b0, 1'b0});
    issue(0, 0, 8'h01, 10);
    check_shadow("final");

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
